// File: rtl/picomem_arbiter_2_1.sv
// rtl/picomem_arbiter_2_1.sv - two-master PicoMem arbiter with per-transaction grant and watchdog
`timescale 1ns/1ps
module picomem_arbiter_2_1 #(
   parameter int          ROUND_ROBIN    = 1,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   // Counter only ever has to hold 0 .. TIMEOUT_CYCLES-1; it simply wraps when the watchdog is off.
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            ptr_q, ptr_d;      // 0 = m0 has priority on a tie, 1 = m1
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            owner_valid;
   logic            expire;
   logic            complete;
   logic            pick_m1;
   logic [31:0]     owner_rdata;

   assign grant = grant_q;

   // State, grant, priority pointer and watchdog counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Arbitration, request forwarding, completion routing and watchdog expiry.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      s_valid     = 1'b0;
      m0_ready    = 1'b0;
      m1_ready    = 1'b0;
      m0_rdata    = 32'h0;
      m1_rdata    = 32'h0;
      timeout_err = 1'b0;
      pick_m1     = 1'b0;
      complete    = 1'b0;
      owner_rdata = 32'h0;

      // Request path follows the registered grant so it is glitch-free within a transaction.
      s_addr      = grant_q[1] ? m1_addr  : m0_addr;
      s_wdata     = grant_q[1] ? m1_wdata : m0_wdata;
      s_wstrb     = grant_q[1] ? m1_wstrb : m0_wstrb;
      owner_valid = grant_q[1] ? m1_valid : m0_valid;

      // A slave ready on the expiry cycle takes precedence, so expiry requires s_ready low.
      expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !s_ready;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (m0_valid || m1_valid) begin
               if (m0_valid && m1_valid)
                  pick_m1 = (ROUND_ROBIN != 0) ? ptr_q : 1'b0;
               else
                  pick_m1 = m1_valid;
               grant_d = pick_m1 ? 2'b10 : 2'b01;
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (!owner_valid) begin
               // Master withdrew its request: release without completing and keep priority.
               state_d = ST_IDLE;
               grant_d = 2'b00;
               cnt_d   = '0;
            end else begin
               s_valid     = !expire;
               complete    = s_ready || expire;
               owner_rdata = expire ? ERR_RDATA : s_rdata;
               timeout_err = expire;
               if (grant_q[1]) begin
                  m1_ready = complete;
                  m1_rdata = owner_rdata;
               end else begin
                  m0_ready = complete;
                  m0_rdata = owner_rdata;
               end
               if (complete) begin
                  state_d = ST_DONE;
                  grant_d = 2'b00;
                  ptr_d   = grant_q[0];   // priority passes to the master that did not own
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         ST_DONE: begin
            // Dead cycle lets the finished master drop valid before it can be re-arbitrated.
            state_d = ST_IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// tb/tb_picomem_arbiter_2_1.sv - directed bench for picomem_arbiter_2_1
`timescale 1ns/1ps
module tb_picomem_arbiter_2_1;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_ready;
   logic [31:0] s_rdata;

   logic        a_m0_ready, a_m1_ready, a_s_valid, a_timeout_err;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
   logic [3:0]  a_s_wstrb;
   logic [1:0]  a_grant;

   logic        b_m0_ready, b_m1_ready, b_s_valid, b_timeout_err;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
   logic [3:0]  b_s_wstrb;
   logic [1:0]  b_grant;

   int checks   = 0;
   int failures = 0;
   int bad;

   always #5 clk = ~clk;

   picomem_arbiter_2_1 #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
      .s_valid(a_s_valid), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(a_grant), .timeout_err(a_timeout_err)
   );

   picomem_arbiter_2_1 #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut_fp (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
      .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(b_grant), .timeout_err(b_timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      m0_valid = 0; m1_valid = 0;
      m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
      m0_wstrb = 4'h0; m1_wstrb = 4'h0;
      s_ready = 0; s_rdata = 32'h0;
      tick(); tick();
      smp();
      chk("reset_grant", {30'h0, a_grant}, 32'h0);
      chk("reset_s_valid", {31'h0, a_s_valid}, 32'h0);
      chk("reset_readies", {30'h0, a_m1_ready, a_m0_ready}, 32'h0);
      chk("reset_timeout", {31'h0, a_timeout_err}, 32'h0);

      // m0 single read, slave ready one cycle after s_valid
      tick();
      reset = 0; m0_valid = 1; m0_addr = 32'h0000_1000; m0_wstrb = 4'h0;
      smp();
      chk("rd_c0_s_valid", {31'h0, a_s_valid}, 32'h0);
      tick();
      smp();
      chk("rd_c1_grant", {30'h0, a_grant}, 32'h1);
      chk("rd_c1_s_valid", {31'h0, a_s_valid}, 32'h1);
      chk("rd_c1_s_addr", a_s_addr, 32'h0000_1000);
      chk("rd_c1_m0_ready", {31'h0, a_m0_ready}, 32'h0);
      tick();
      s_ready = 1; s_rdata = 32'h1234_5678;
      smp();
      chk("rd_c2_m0_ready", {31'h0, a_m0_ready}, 32'h1);
      chk("rd_c2_m0_rdata", a_m0_rdata, 32'h1234_5678);
      chk("rd_c2_m1_ready", {31'h0, a_m1_ready}, 32'h0);
      tick();
      s_ready = 0; m0_valid = 0;
      smp();
      chk("rd_done_grant", {30'h0, a_grant}, 32'h0);
      chk("rd_done_m0_ready", {31'h0, a_m0_ready}, 32'h0);

      // m1 write with a 5-cycle slave wait
      tick();
      m1_valid = 1; m1_addr = 32'h4000_0004; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
      tick();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         smp();
         if (a_s_valid !== 1'b1 || a_s_addr !== 32'h4000_0004 || a_s_wdata !== 32'hA5A5_A5A5 ||
             a_s_wstrb !== 4'hF || a_m1_ready !== 1'b0 || a_m0_ready !== 1'b0 || a_grant !== 2'b10)
            bad++;
         tick();
      end
      chk("wr_wait_stable_bad_cycles", bad, 0);
      s_ready = 1;
      smp();
      chk("wr_m1_ready", {31'h0, a_m1_ready}, 32'h1);
      chk("wr_m0_ready", {31'h0, a_m0_ready}, 32'h0);
      tick();
      s_ready = 0; m1_valid = 0; m1_wstrb = 4'h0;
      smp();
      chk("wr_done_m1_ready", {31'h0, a_m1_ready}, 32'h0);
      chk("wr_done_s_valid", {31'h0, a_s_valid}, 32'h0);

      // watchdog expiry after 8 BUSY cycles
      tick();
      m0_valid = 1; m0_addr = 32'h0000_2000;
      tick();
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         smp();
         if (a_s_valid !== 1'b1 || a_timeout_err !== 1'b0 || a_m0_ready !== 1'b0)
            bad++;
         tick();
      end
      chk("to_pre_expiry_bad_cycles", bad, 0);
      smp();
      chk("to_m0_ready", {31'h0, a_m0_ready}, 32'h1);
      chk("to_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
      chk("to_timeout_err", {31'h0, a_timeout_err}, 32'h1);
      chk("to_s_valid", {31'h0, a_s_valid}, 32'h0);
      tick();
      m0_valid = 0;
      smp();
      chk("to_done_timeout_err", {31'h0, a_timeout_err}, 32'h0);
      chk("to_done_grant", {30'h0, a_grant}, 32'h0);
      tick();
      m1_valid = 1; m1_addr = 32'h0000_3000; s_ready = 1; s_rdata = 32'h0000_0055;
      tick();
      smp();
      chk("to_next_grant", {30'h0, a_grant}, 32'h2);
      chk("to_next_m1_ready", {31'h0, a_m1_ready}, 32'h1);
      chk("to_next_m1_rdata", a_m1_rdata, 32'h0000_0055);
      chk("to_next_timeout_err", {31'h0, a_timeout_err}, 32'h0);
      tick();
      m1_valid = 0; s_ready = 0;
      tick();

      // s_ready arrives on the expiry cycle
      m0_valid = 1; m0_addr = 32'h0000_4000;
      tick();
      for (int i = 0; i < 7; i++) tick();
      s_ready = 1; s_rdata = 32'h0BAD_F00D;
      smp();
      chk("race_m0_ready", {31'h0, a_m0_ready}, 32'h1);
      chk("race_m0_rdata", a_m0_rdata, 32'h0BAD_F00D);
      chk("race_timeout_err", {31'h0, a_timeout_err}, 32'h0);
      chk("race_s_valid", {31'h0, a_s_valid}, 32'h1);
      tick();
      m0_valid = 0; s_ready = 0;
      tick();

      // contested arbitration, zero-wait slave: round robin vs fixed priority
      reset = 1;
      tick();
      reset = 0; m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h0000_00AA;
      for (int t = 0; t < 4; t++) begin
         tick();
         smp();
         chk($sformatf("rr_grant_%0d", t), {30'h0, a_grant}, (t % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr_readies_%0d", t), {30'h0, a_m1_ready, a_m0_ready},
             (t % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("fp_grant_%0d", t), {30'h0, b_grant}, 32'h1);
         chk($sformatf("fp_m1_ready_%0d", t), {31'h0, b_m1_ready}, 32'h0);
         tick();
         tick();
      end

      // reset in the middle of BUSY, then a pending m1 request
      m1_valid = 0; s_ready = 0;
      tick();
      smp();
      chk("rst_busy_grant", {30'h0, a_grant}, 32'h1);
      reset = 1; m1_valid = 1; m1_addr = 32'h0000_5000;
      tick();
      smp();
      chk("rst_grant", {30'h0, a_grant}, 32'h0);
      chk("rst_s_valid", {31'h0, a_s_valid}, 32'h0);
      chk("rst_readies", {30'h0, a_m1_ready, a_m0_ready}, 32'h0);
      reset = 0; m0_valid = 0;
      tick();
      smp();
      chk("post_rst_grant", {30'h0, a_grant}, 32'h2);
      chk("post_rst_s_addr", a_s_addr, 32'h0000_5000);
      chk("post_rst_s_valid", {31'h0, a_s_valid}, 32'h1);
      tick();
      m1_valid = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/picomem_arbiter_2_1.md
Name: picomem_arbiter_2_1

Overview:
- Shares one PicoMem slave port between two PicoMem masters, e.g. the CPU (m0) and a DMA/debug master (m1).
- Sits upstream of the 1-to-4 address mux, so the whole peripheral map behaves as a single shared resource.
- Per-transaction grant with round-robin or fixed priority.
- A watchdog completes any transaction that the slave never acknowledges, returning an error.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate priority after each completed grant; 0 = m0 always wins ties.
- TIMEOUT_CYCLES, 1024: number of busy cycles without slave ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_valid / m1_valid  in  1  master request.
- m0_addr / m1_addr  in  32  master address.
- m0_wdata / m1_wdata  in  32  master write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read.
- m0_ready / m1_ready  out  1  transaction complete to that master.
- m0_rdata / m1_rdata  out  32  read data to that master.
- s_valid  out  1  request to the shared slave.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_wstrb  out  4  forwarded strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot owner; 00 = idle.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (sync, active-high): state IDLE, grant=00, s_valid=0, m0_ready=m1_ready=0, timeout_err=0, watchdog counter=0, priority pointer=m0. Reset mid-transaction drops s_valid on the next edge; the master receives no ready.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No valid: stay in IDLE.
  - Only one valid: grant that master.
  - Both valid: grant the pointer master (ROUND_ROBIN=1) or m0 (ROUND_ROBIN=0).
  - Grant is registered; next state is BUSY. Arbitration latency is 1 cycle: s_valid rises one cycle after the first m*_valid.
- BUSY:
  - s_valid = owner valid; s_addr/s_wdata/s_wstrb = owner's signals (combinational mux on registered grant).
  - m<owner>_ready = s_ready; m<owner>_rdata = s_rdata. Non-owner ready=0, rdata=0.
  - s_ready=1 → DONE; pointer moves to the non-owner.
  - Owner valid drops before ready (abort) → IDLE, no ready, pointer unchanged.
  - Watchdog counter increments each BUSY cycle with s_ready=0.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with s_ready still 0, on that cycle:
    - s_valid forced 0;
    - owner ready=1, owner rdata=ERR_RDATA;
    - timeout_err=1;
    - next state DONE; pointer advances.
  - s_ready and expiry in the same cycle: s_ready wins; normal completion, no error.
- DONE: one dead cycle. grant=00, s_valid=0, all readies 0, counter cleared, then IDLE. This guarantees the master has dropped valid before re-arbitration, so a completed request is never re-issued.
- When a master's ready=1 and wstrb≠0, the write is committed exactly once at the slave.
- Back-to-back throughput: 3 cycles minimum per transaction (IDLE → BUSY → DONE) with a zero-wait slave.
- Non-owner requests wait with no timeout. With ROUND_ROBIN=1, starvation is bounded to one transaction.
- Invariants:
  - grant is one-hot or zero.
  - s_valid=0 whenever grant=00.
  - m0_ready & m1_ready is never 1.

Test Plan:
- m0 single read, slave ready 1 cycle after s_valid, s_rdata=0x12345678 → s_valid at cycle 1; m0_ready pulse at cycle 2 with rdata 0x12345678; grant 01→00 in DONE.
- m0 and m1 both valid continuously with ROUND_ROBIN=1, 0-wait slave → grants alternate 01,10,01,10. With ROUND_ROBIN=0 → m0 wins every contested arbitration.
- m1 write addr 0x40000004, wdata 0xA5A5A5A5, wstrb 0xF, slave waits 5 cycles → s_* hold m1 values stable for all 5 cycles; exactly one m1_ready; m0_ready stays 0.
- TIMEOUT_CYCLES=8, slave never ready → after 8 BUSY cycles the owner sees ready=1 with rdata 0xDEADBEEF; timeout_err pulses once; s_valid=0 on that cycle; the next request is then granted normally.
- s_ready arrives exactly on the expiry cycle → normal completion with the slave data; timeout_err stays 0.
- reset=1 asserted mid-BUSY → next cycle grant=00, s_valid=0, no ready. After reset release, a pending m1 request is granted first if m0 is idle.
